uart_tx_path: RTL and testbench

//   Transmit path of the AHB-Lite UART16550: consumes bytes written to the THR by the bus-side

---
 rtl/uart_tx_path.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_path.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_path.sv
// UART16550 transmit path: THR FIFO feeding a 16x-oversampled frame serialiser.
// Frame format is captured from LCR when each byte leaves the FIFO.
module uart_tx_path #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             baud_tick,
  input  logic [1:0]       lcr_wls,
  input  logic             lcr_stb,
  input  logic             lcr_pen,
  input  logic             lcr_eps,
  input  logic             lcr_brk,
  input  logic             fifo_clr,
  output logic             stx,
  output logic             thr_empty,
  output logic             tx_idle,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty, pop, push;

  state_t     state, state_n;
  logic [4:0] tick_cnt, tick_n, stop_last;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] shift, shift_n, head_mask;
  logic [1:0] wls_q, wls_n;
  logic       stb_q, stb_n, pen_q, pen_n, par_q, par_n, stx_q, stx_n, bit_end;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign pop   = (state == IDLE) && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign push  = wr_en && !fifo_clr && (!full || pop);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (fifo_clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count + CNT_W'(push) - CNT_W'(pop);
      overflow <= wr_en && full && !pop;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign head_mask = 8'hFF >> (2'd3 - lcr_wls);
  assign bit_end   = baud_tick && (tick_cnt[3:0] == 4'hF);
  // Stop length in ticks minus one: 16, 32, or 24 for the 1.5-stop 5-bit case.
  assign stop_last = !stb_q ? 5'd15 : (wls_q == 2'd0) ? 5'd23 : 5'd31;

  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    shift_n = shift;
    wls_n   = wls_q;
    stb_n   = stb_q;
    pen_n   = pen_q;
    par_n   = par_q;
    stx_n   = stx_q;
    if (state != IDLE && state != STOP && baud_tick)
      tick_n = bit_end ? 5'd0 : tick_cnt + 5'd1;
    case (state)
      IDLE: begin
        stx_n = 1'b1;
        if (pop) begin
          state_n = START;
          shift_n = mem[rd_ptr];
          wls_n   = lcr_wls;
          stb_n   = lcr_stb;
          pen_n   = lcr_pen;
          par_n   = lcr_eps ? ^(mem[rd_ptr] & head_mask) : ~^(mem[rd_ptr] & head_mask);
          tick_n  = 5'd0;
          bit_n   = 3'd0;
          stx_n   = 1'b0;
        end
      end
      START: begin
        stx_n = 1'b0;
        if (bit_end) begin
          state_n = DATA;
          stx_n   = shift[0];
        end
      end
      DATA: begin
        stx_n = shift[0];
        if (bit_end) begin
          shift_n = shift >> 1;
          bit_n   = bit_cnt + 3'd1;
          if (bit_cnt == {1'b0, wls_q} + 3'd4) begin
            state_n = pen_q ? PARITY : STOP;
            stx_n   = pen_q ? par_q : 1'b1;
          end else begin
            stx_n = shift_n[0];
          end
        end
      end
      PARITY: begin
        stx_n = par_q;
        if (bit_end) begin
          state_n = STOP;
          stx_n   = 1'b1;
        end
      end
      STOP: begin
        stx_n = 1'b1;
        if (baud_tick) begin
          if (tick_cnt == stop_last) begin
            state_n = IDLE;
            tick_n  = 5'd0;
          end else begin
            tick_n = tick_cnt + 5'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        stx_n   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      wls_q    <= '0;
      stb_q    <= 1'b0;
      pen_q    <= 1'b0;
      par_q    <= 1'b0;
      stx_q    <= 1'b1;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
      wls_q    <= wls_n;
      stb_q    <= stb_n;
      pen_q    <= pen_n;
      par_q    <= par_n;
      stx_q    <= stx_n;
    end
  end

  assign stx        = lcr_brk ? 1'b0 : stx_q;
  assign thr_empty  = empty;
  assign tx_idle    = empty && (state == IDLE);
  assign fifo_count = count;
endmodule

// File: tb/tb_uart_tx_path.sv
// Bench for uart_tx_path: expected frames are queued at write time and a serial
// monitor decodes stx against them, counting baud ticks to locate bit centres.
module tb_uart_tx_path;
  logic       HCLK = 1'b0, HRESETn = 1'b0, wr_en = 1'b0, baud_tick = 1'b0;
  logic       lcr_stb = 1'b0, lcr_pen = 1'b0, lcr_eps = 1'b0, lcr_brk = 1'b0, fifo_clr = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [1:0] lcr_wls = 2'd3;
  logic       stx, thr_empty, tx_idle, overflow;
  logic [4:0] fifo_count;

  typedef struct {
    logic [7:0] data;
    logic [1:0] wls;
    logic       pen, eps, stb;
  } frame_t;

  frame_t exp_q[$];
  int     errors = 0, checks = 0, tk = 0, div = 0;
  bit     tick_en = 1'b0, ignore = 1'b0;
  logic   stx_prev = 1'b1;

  always #5 HCLK = ~HCLK;

  uart_tx_path dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .wr_en(wr_en), .wr_data(wr_data),
    .baud_tick(baud_tick), .lcr_wls(lcr_wls), .lcr_stb(lcr_stb), .lcr_pen(lcr_pen),
    .lcr_eps(lcr_eps), .lcr_brk(lcr_brk), .fifo_clr(fifo_clr), .stx(stx),
    .thr_empty(thr_empty), .tx_idle(tx_idle), .fifo_count(fifo_count), .overflow(overflow)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // 16x baud enable, one cycle in four when running
  initial forever begin
    @(posedge HCLK); #1;
    baud_tick = tick_en && (div == 3);
    div = (div + 1) % 4;
  end

  task automatic upto(int t);
    int g = 0;
    while (tk < t && g < 5000) begin
      @(negedge HCLK);
      g++;
      if (baud_tick) tk++;
    end
    if (tk < t) chk("mon_tick_timeout", 32'(tk), 32'(t));
  endtask

  // Monitor: on each start edge, pop the expected frame and check every bit at its centre
  initial begin
    frame_t f;
    int nb, np, ns;
    logic par;
    forever begin
      @(negedge HCLK);
      if (stx_prev === 1'b1 && stx === 1'b0 && !lcr_brk && !ignore) begin
        if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
        else begin
          f  = exp_q.pop_front();
          nb = int'(f.wls) + 5;
          np = f.pen ? 1 : 0;
          ns = f.stb ? ((f.wls == 2'd0) ? 24 : 32) : 16;
          par = 1'b0;
          for (int i = 0; i < nb; i++) par ^= f.data[i];
          if (!f.eps) par = ~par;
          tk = baud_tick ? 1 : 0;
          upto(8);
          chk("start_bit", stx, 0);
          for (int i = 0; i < nb; i++) begin
            upto(16 * (i + 1) + 8);
            chk($sformatf("data_bit%0d_of_%02h", i, f.data), stx, f.data[i]);
          end
          if (np == 1) begin
            upto(16 * (nb + 1) + 8);
            chk("parity_bit", stx, par);
          end
          upto(16 * (1 + nb + np) + 8);
          chk("stop_mid", stx, 1);
          upto(16 * (1 + nb + np) + ns);
          chk("stop_last_tick", stx, 1);
          chk("stop_busy", tx_idle, 0);
          @(negedge HCLK);
          chk("frame_end_state", tx_idle, thr_empty);
        end
      end
      stx_prev = stx;
    end
  end

  task automatic wr(logic [7:0] b, bit expect_it);
    @(posedge HCLK); #1;
    wr_en = 1'b1;
    wr_data = b;
    if (expect_it) exp_q.push_back('{b, lcr_wls, lcr_pen, lcr_eps, lcr_stb});
    @(posedge HCLK); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(int lim);
    int g = 0;
    while (tx_idle !== 1'b1 && g < lim) begin
      @(posedge HCLK); #1;
      g++;
    end
    chk("wait_idle", tx_idle, 1);
    repeat (3) @(posedge HCLK);
    #1;
  endtask

  task automatic set_lcr(logic [1:0] w, logic p, logic e, logic s);
    lcr_wls = w; lcr_pen = p; lcr_eps = e; lcr_stb = s;
  endtask

  initial begin
    int g;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_stx", stx, 1);
    chk("rst_thr_empty", thr_empty, 1);
    chk("rst_tx_idle", tx_idle, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    HRESETn = 1'b1;
    tick_en = 1'b1;

    // 8N1 0xA5, then 7E2 0x41, then 5O1.5 0x1F
    set_lcr(2'd3, 0, 0, 0); wr(8'hA5, 1); wait_idle(3000);
    chk("a5_idle_stx", stx, 1);
    set_lcr(2'd2, 1, 1, 1); wr(8'h41, 1); wait_idle(3000);
    set_lcr(2'd0, 1, 0, 1); wr(8'h1F, 1); wait_idle(3000);

    // LCR change mid-frame must not disturb the frame already loaded
    set_lcr(2'd3, 0, 0, 0); wr(8'h5A, 1);
    repeat (100) @(posedge HCLK);
    #1;
    set_lcr(2'd0, 1, 1, 1);
    wait_idle(3000);
    set_lcr(2'd3, 0, 0, 0);

    // Fill with ticks stopped: first byte sits in the shifter, 16 in the FIFO
    tick_en = 1'b0;
    @(posedge HCLK); #1;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h10 + i);
      exp_q.push_back('{wr_data, lcr_wls, lcr_pen, lcr_eps, lcr_stb});
      @(posedge HCLK); #1;
    end
    wr_en = 1'b0;
    chk("fill_count", fifo_count, 16);
    chk("fill_no_ovf", overflow, 0);
    wr_en = 1'b1; wr_data = 8'hEE;
    @(posedge HCLK); #1;
    wr_en = 1'b0;
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", fifo_count, 16);
    @(posedge HCLK); #1;
    chk("ovf_one_cycle", overflow, 0);

    // Hold a write while full; the cycle the head pops it must be accepted
    wr_en = 1'b1; wr_data = 8'h3C;
    tick_en = 1'b1;
    g = 0;
    do begin
      @(posedge HCLK); #1;
      g++;
    end while (overflow !== 1'b0 && g < 5000);
    wr_en = 1'b0;
    chk("pushpop_seen", 32'(g < 5000), 1);
    exp_q.push_back('{8'h3C, lcr_wls, lcr_pen, lcr_eps, lcr_stb});
    chk("pushpop_count", fifo_count, 16);
    wait_idle(20000);

    // fifo_clr mid-frame with three bytes queued; a same-cycle write is dropped
    @(posedge HCLK); #1;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h81 + i);
      if (i == 0) exp_q.push_back('{wr_data, lcr_wls, lcr_pen, lcr_eps, lcr_stb});
      @(posedge HCLK); #1;
    end
    wr_en = 1'b0;
    repeat (150) @(posedge HCLK);
    #1;
    chk("clr_pre_count", fifo_count, 3);
    fifo_clr = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
    @(posedge HCLK); #1;
    fifo_clr = 1'b0; wr_en = 1'b0;
    chk("clr_count", fifo_count, 0);
    chk("clr_no_ovf", overflow, 0);
    chk("clr_thr_empty", thr_empty, 1);
    chk("clr_frame_running", tx_idle, 0);
    wait_idle(3000);
    repeat (300) @(posedge HCLK);
    #1;
    chk("clr_quiet_stx", stx, 1);

    // Break override at idle
    lcr_brk = 1'b1; #1;
    chk("brk_stx", stx, 0);
    chk("brk_idle", tx_idle, 1);
    lcr_brk = 1'b0; #1;
    chk("brk_release", stx, 1);

    // Reset in the middle of a frame with bytes still queued
    ignore = 1'b1;
    wr(8'h00, 0); wr(8'h55, 0); wr(8'h66, 0);
    repeat (150) @(posedge HCLK);
    #1;
    chk("mid_frame_stx", stx, 0);
    chk("mid_frame_count", fifo_count, 2);
    HRESETn = 1'b0;
    @(posedge HCLK); #1;
    chk("mrst_stx", stx, 1);
    chk("mrst_count", fifo_count, 0);
    chk("mrst_thr_empty", thr_empty, 1);
    chk("mrst_tx_idle", tx_idle, 1);
    lcr_brk = 1'b1; #1;
    chk("mrst_brk", stx, 0);
    lcr_brk = 1'b0;
    HRESETn = 1'b1;
    repeat (200) @(posedge HCLK);
    #1;
    chk("post_rst_stx", stx, 1);
    chk("post_rst_idle", tx_idle, 1);
    ignore = 1'b0;

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
